// File: rtl/writeback_retire.sv
// Writeback/retire stage: registered rf write, in-order retire queue, drain-then-flush on exception.
// Optional trace output when WRB_TRACE_EN is defined.
module writeback_retire #(
    parameter int          ADDR_WIDTH = 30,
    parameter int          INSN_WIDTH = 32,
    parameter int          XLEN       = 32,
    parameter int          REG_AW     = 5,
    parameter int unsigned RQ_DEPTH   = 4,
    parameter int          CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [INSN_WIDTH-1:0] in_insn,
    input  logic [REG_AW-1:0]     in_rd,
    input  logic                  in_rd_we,
    input  logic [XLEN-1:0]       in_result,
    input  logic                  in_except,
    output logic                  rf_we,
    output logic [REG_AW-1:0]     rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic                  ret_valid,
    input  logic                  ret_ready,
    output logic [ADDR_WIDTH-1:0] ret_addr,
    output logic [INSN_WIDTH-1:0] ret_insn,
    output logic                  ret_except,
    output logic                  flush,
    output logic [CNT_WIDTH-1:0]  retired_count
);

    localparam int unsigned IDX_W = $clog2(RQ_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] q_addr   [RQ_DEPTH];
    logic [INSN_WIDTH-1:0] q_insn   [RQ_DEPTH];
    logic                  q_except [RQ_DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             empty, full, push, pop;

    // Extra pointer bit: equal low bits with differing MSB means full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

    assign ret_valid  = !empty;
    assign pop        = ret_valid && ret_ready;
    assign in_ready   = (state == RUN) && (!full || pop);
    assign push       = in_valid && in_ready;

    assign ret_addr   = q_addr[rd_ptr[IDX_W-1:0]];
    assign ret_insn   = q_insn[rd_ptr[IDX_W-1:0]];
    assign ret_except = q_except[rd_ptr[IDX_W-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < RQ_DEPTH; i++) begin
                q_addr[i]   <= '0;
                q_insn[i]   <= '0;
                q_except[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                q_addr[wr_ptr[IDX_W-1:0]]   <= in_addr;
                q_insn[wr_ptr[IDX_W-1:0]]   <= in_insn;
                q_except[wr_ptr[IDX_W-1:0]] <= in_except;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we         <= 1'b0;
            rf_waddr      <= '0;
            rf_wdata      <= '0;
            retired_count <= '0;
        end else begin
            rf_we <= push && in_rd_we && (in_rd != '0) && !in_except;
            if (push) begin
                rf_waddr <= in_rd;
                rf_wdata <= in_result;
            end
            if (pop) begin
                retired_count <= retired_count + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        flush     = 1'b0;
        case (state)
            RUN: begin
                if (push && in_except) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (empty) state_nxt = FLUSH;
            end
            FLUSH: begin
                flush     = 1'b1;
                state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

`ifdef WRB_TRACE_EN
`ifndef MSG
`define MSG(lvl, body) $display body
`endif
    always @(posedge clk) begin
        if (rst && push)
            `MSG(5, ("WRB: addr=%h op=%h", {in_addr, 2'b00}, in_insn));
        if (rst && pop)
            `MSG(5, ("RET: addr=%h exc=%b cnt=%0d", {ret_addr, 2'b00}, ret_except,
                     retired_count + CNT_WIDTH'(1)));
    end
`endif

endmodule

// File: tb/tb_writeback_retire.sv
// Self-checking bench for writeback_retire: reference model plus retire-record scoreboard.
module tb_writeback_retire;

    localparam int AW    = 30;
    localparam int IW    = 32;
    localparam int XL    = 32;
    localparam int RAW   = 5;
    localparam int DEPTH = 4;
    localparam int CW    = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [IW-1:0] insn;
        logic          exc;
    } rec_t;

    typedef enum int {M_RUN, M_DRAIN, M_FLUSH} mstate_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [AW-1:0]  in_addr = '0;
    logic [IW-1:0]  in_insn = '0;
    logic [RAW-1:0] in_rd = '0;
    logic           in_rd_we = 1'b0;
    logic [XL-1:0]  in_result = '0;
    logic           in_except = 1'b0;
    logic           rf_we;
    logic [RAW-1:0] rf_waddr;
    logic [XL-1:0]  rf_wdata;
    logic           ret_valid;
    logic           ret_ready = 1'b0;
    logic [AW-1:0]  ret_addr;
    logic [IW-1:0]  ret_insn;
    logic           ret_except;
    logic           flush;
    logic [CW-1:0]  retired_count;

    int tests_run = 0;
    int tests_failed = 0;

    rec_t           sb[$];
    mstate_t        m_state = M_RUN;
    logic [CW-1:0]  m_cnt = '0;
    logic           exp_we = 1'b0;
    logic [RAW-1:0] exp_waddr = '0;
    logic [XL-1:0]  exp_wdata = '0;
    int             flush_seen = 0;

    always #5 clk = ~clk;

    writeback_retire #(
        .ADDR_WIDTH (AW),
        .INSN_WIDTH (IW),
        .XLEN       (XL),
        .REG_AW     (RAW),
        .RQ_DEPTH   (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_addr       (in_addr),
        .in_insn       (in_insn),
        .in_rd         (in_rd),
        .in_rd_we      (in_rd_we),
        .in_result     (in_result),
        .in_except     (in_except),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .ret_valid     (ret_valid),
        .ret_ready     (ret_ready),
        .ret_addr      (ret_addr),
        .ret_insn      (ret_insn),
        .ret_except    (ret_except),
        .flush         (flush),
        .retired_count (retired_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: check/advance the model at negedge, then return just after the next posedge.
    task automatic tick();
        logic m_pop, m_ready, m_acc;
        rec_t r;
        int   occ;
        @(negedge clk);
        if (!rst_n) begin
            sb.delete();
            m_state = M_RUN;
            m_cnt   = '0;
            exp_we  = 1'b0;
        end else begin
            occ     = sb.size();
            m_pop   = (occ > 0) && ret_ready;
            m_ready = (m_state == M_RUN) && ((occ < DEPTH) || m_pop);
            check("in_ready", 64'(in_ready), 64'(m_ready));
            check("ret_valid", 64'(ret_valid), 64'(occ > 0));
            check("flush", 64'(flush), 64'(m_state == M_FLUSH));
            check("rf_we", 64'(rf_we), 64'(exp_we));
            if (exp_we) begin
                check("rf_waddr", 64'(rf_waddr), 64'(exp_waddr));
                check("rf_wdata", 64'(rf_wdata), 64'(exp_wdata));
            end
            check("retired_count", 64'(retired_count), 64'(m_cnt));
            if (flush) flush_seen++;
            if (m_pop) begin
                r = sb.pop_front();
                check("ret_addr", 64'(ret_addr), 64'(r.addr));
                check("ret_insn", 64'(ret_insn), 64'(r.insn));
                check("ret_except", 64'(ret_except), 64'(r.exc));
                m_cnt = m_cnt + 1'b1;
            end
            m_acc = in_valid && m_ready;
            if (m_acc) begin
                r.addr = in_addr;
                r.insn = in_insn;
                r.exc  = in_except;
                sb.push_back(r);
            end
            exp_we = m_acc && in_rd_we && (in_rd != '0) && !in_except;
            if (m_acc) begin
                exp_waddr = in_rd;
                exp_wdata = in_result;
            end
            case (m_state)
                M_RUN:   if (m_acc && in_except) m_state = M_DRAIN;
                M_DRAIN: if (occ == 0) m_state = M_FLUSH;
                default: m_state = M_RUN;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [AW-1:0] a, input logic [IW-1:0] i, input logic [RAW-1:0] rd,
                         input logic we, input logic [XL-1:0] res, input logic exc);
        in_valid  = 1'b1;
        in_addr   = a;
        in_insn   = i;
        in_rd     = rd;
        in_rd_we  = we;
        in_result = res;
        in_except = exc;
    endtask

    task automatic idle_until_empty(input int limit);
        in_valid = 1'b0;
        ret_ready = 1'b1;
        for (int i = 0; i < limit && (sb.size() != 0 || m_state != M_RUN); i++) tick();
        check("drain_done", 64'(sb.size()), 64'(0));
        tick();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #2;
        check("reset_ret_valid", 64'(ret_valid), 64'(0));
        check("reset_rf_we", 64'(rf_we), 64'(0));
        check("reset_flush", 64'(flush), 64'(0));
        check("reset_count", 64'(retired_count), 64'(0));
        do_reset();
        check("reset_in_ready", 64'(in_ready), 64'(1));

        // Single accept, then rd=0 write suppression.
        ret_ready = 1'b0;
        drive(30'h100, 32'h00A00093, 5'd1, 1'b1, 32'hA, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        check("t1_ret_addr", 64'(ret_addr), 64'h100);
        ret_ready = 1'b1;
        tick();
        check("t1_count", 64'(retired_count), 64'd1);
        drive(30'h104, 32'h00000013, 5'd0, 1'b1, 32'h55, 1'b0);
        tick();
        idle_until_empty(10);

        // Fill the queue, then push and pop together at full.
        ret_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            drive(AW'(32'h200 + k), IW'(32'h1000 + k), RAW'(k + 2), 1'b1, XL'(32'hB0 + k), 1'b0);
            tick();
        end
        drive(30'h2FF, 32'h2FFF, 5'd9, 1'b1, 32'hCC, 1'b0);
        tick();
        check("t3_full_ready", 64'(in_ready), 64'(0));
        ret_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        ret_ready = 1'b0;
        tick();
        check("t3_occupancy", 64'(sb.size()), 64'(DEPTH));
        idle_until_empty(20);

        // Exception on the middle bundle of three.
        flush_seen = 0;
        ret_ready = 1'b1;
        drive(30'h300, 32'h3000, 5'd3, 1'b1, 32'h31, 1'b0);
        tick();
        drive(30'h301, 32'h3001, 5'd4, 1'b1, 32'h32, 1'b1);
        tick();
        drive(30'h302, 32'h3002, 5'd5, 1'b1, 32'h33, 1'b0);
        for (int i = 0; i < 20 && m_state != M_RUN; i++) tick();
        check("t4_back_to_run", 64'(m_state == M_RUN), 64'(1));
        idle_until_empty(20);
        check("t4_flush_pulses", 64'(flush_seen), 64'(1));

        // Asynchronous reset with queued records.
        ret_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(AW'(32'h400 + k), IW'(32'h4000 + k), 5'd7, 1'b1, XL'(k), 1'b0);
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_ret_valid", 64'(ret_valid), 64'(0));
        check("t5_count", 64'(retired_count), 64'(0));
        check("t5_rf_we", 64'(rf_we), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // Counter wrap through 17 pops with a 4-bit counter.
        ret_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            drive(AW'(32'h500 + k), IW'($urandom), RAW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  XL'($urandom), 1'b0);
            tick();
        end
        idle_until_empty(20);
        check("t6_count_wrap", 64'(retired_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/writeback_retire.md
Name: writeback_retire

Overview:
Parametrised successor to the single-slot writeback stage. It accepts completed instruction bundles from execute over a valid/ready handshake and performs the register-file write one cycle later. In parallel it buffers retire records in a RQ_DEPTH-entry in-order queue that drains to the retire/commit consumer. It also handles excepting instructions with a drain-then-flush state machine, and keeps a running retired-instruction count.

Parameters:
ADDR_WIDTH, 30, word address width; byte address is {addr, 2'b00}
INSN_WIDTH, 32, instruction encoding width
XLEN, 32, result/register data width
REG_AW, 5, register index width
RQ_DEPTH, 4, retire queue entries; power of two, >=2
CNT_WIDTH, 32, retired counter width

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-low
in_valid  in  1  execute bundle valid
in_ready  out  1  stage can accept a bundle this cycle
in_addr  in  ADDR_WIDTH  instruction word address
in_insn  in  INSN_WIDTH  instruction encoding
in_rd  in  REG_AW  destination register
in_rd_we  in  1  instruction writes rd
in_result  in  XLEN  result data
in_except  in  1  instruction raised an exception
rf_we  out  1  register-file write enable
rf_waddr  out  REG_AW  register-file write index
rf_wdata  out  XLEN  register-file write data
ret_valid  out  1  retire record available
ret_ready  in  1  consumer takes record
ret_addr  out  ADDR_WIDTH  retiring instruction address
ret_insn  out  INSN_WIDTH  retiring instruction encoding
ret_except  out  1  retiring instruction is excepting
flush  out  1  one-cycle pipeline flush request
retired_count  out  CNT_WIDTH  number of records popped, modulo 2^CNT_WIDTH

Behaviour:
- Clocking and reset:
  - clk is the only clock.
  - rst is asynchronous, active-low. All flops clear immediately on rst=0.
  - Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, ret_valid=0, flush=0, retired_count=0.
  - After reset: queue empty, state=RUN, in_ready=1.
  - Reset mid-operation discards all queued records and any pending write.
- Accept:
  - A bundle is accepted when in_valid && in_ready.
  - in_ready = (state==RUN) && (queue not full || pop this cycle). A simultaneous push and pop at full is legal; occupancy is unchanged.
- Register write:
  - Registered; asserted the cycle after accept.
  - rf_we=1 only if in_rd_we && in_rd!=0 && !in_except. rf_waddr/rf_wdata carry the accepted in_rd/in_result.
  - rf_we=0 in every other cycle.
- Retire queue:
  - Each accept pushes {addr, insn, except}.
  - ret_valid = queue not empty. Head outputs are stable while ret_valid && !ret_ready.
  - A pop occurs on ret_valid && ret_ready. Records leave strictly in order.
  - Read/write pointers wrap modulo RQ_DEPTH. A pointer-extension bit distinguishes full from empty.
  - Push to an empty queue: ret_valid rises the next cycle (no combinational bypass).
- retired_count:
  - Increments by 1 on each pop.
  - Wraps from all-ones to 0.
- State machine:
  - RUN:
    - Normal operation.
    - Accept with in_except=1 -> DRAIN. Record is pushed; no rf write.
  - DRAIN:
    - in_ready=0.
    - Stays in DRAIN until the queue is empty, i.e. the excepting record has been popped.
    - Then -> FLUSH.
  - FLUSH:
    - flush=1 for exactly one cycle; in_ready=0.
    - -> RUN.
- Simultaneous events:
  - An exception accepted while the queue is full is legal only when a pop occurs in the same cycle.
  - An rf write from the prior accept completes regardless of the state transition.

Optional Feature:
WRB_TRACE_EN:
- Defined: emits `MSG(5, ...)` per accept ("WRB: addr=%h op=%h" with byte address) and per pop ("RET: addr=%h exc=%b cnt=%0d").
- Undefined: no trace statements are compiled.
- Functional behaviour and port list are identical either way.

Test Plan:
1. Reset then single accept: addr=0x100, insn=0x00A00093, rd=1, we=1, result=0xA -> next cycle rf_we=1, rf_waddr=1, rf_wdata=0xA. ret_valid=1 with ret_addr=0x100. After pop, retired_count=1.
2. rd=0 with we=1 -> rf_we stays 0. The record still retires.
3. ret_ready=0, push 4 bundles (RQ_DEPTH=4) -> in_ready=0 after the 4th. Then ret_ready=1 with a 5th bundle offered -> push and pop in the same cycle, occupancy stays 4, order preserved.
4. Exception on 2nd of 3 bundles -> no rf write for bundle 2. in_ready=0 once bundle 2 is accepted, so bundle 3 is not accepted. After record 2 is popped, flush=1 for one cycle, then in_ready=1.
5. Assert rst=0 asynchronously with 3 queued records -> ret_valid=0, retired_count=0, rf_we=0 without waiting for a clock edge.
6. Preload retired_count near wrap (force or CNT_WIDTH=4), pop 17 records -> count reads 1.
